// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_arbiter_rr.sv
// Combinational two-way round-robin pick: one-hot select among valid requesters.
module bus_arbiter_rr
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] sel
);

  // prio=0 favours m0, prio=1 favours m1; only matters when both request
  always_comb begin
    sel = 2'b00;
    case (valid)
      2'b01:   sel = 2'b01;
      2'b10:   sel = 2'b10;
      2'b11:   sel = prio ? 2'b10 : 2'b01;
      default: sel = 2'b00;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master to one-peripheral arbiter with round-robin grant and a BUSY-state
// timeout that returns ERR_RDATA to the owner if the peripheral never answers.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int                TIMEOUT   = 16,
  parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [STRB_W-1:0] m0_wstrb,
  input  logic [DATA_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic [DATA_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [STRB_W-1:0] s_wstrb,
  output logic [DATA_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        grant,
  output logic              timeout
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t            state;
  logic              prio;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        pick;
  logic              finish;
  logic [DATA_W-1:0] rsp;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  bus_arbiter_rr u_rr (
    .valid ({m1_valid, m0_valid}),
    .prio  (prio),
    .sel   (pick)
  );

  // A ready on the expiring cycle wins over the timeout
  assign finish = s_ready || (cnt == CNT_LAST);
  assign rsp    = s_ready ? s_rdata : ERR_RDATA;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prio     <= 1'b0;
      cnt      <= '0;
      s_valid  <= 1'b0;
      s_wstrb  <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      grant    <= 2'b00;
      timeout  <= 1'b0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (|pick) begin
            grant   <= pick;
            s_valid <= 1'b1;
            s_wstrb <= pick[1] ? m1_wstrb : m0_wstrb;
            s_addr  <= pick[1] ? m1_addr  : m0_addr;
            s_wdata <= pick[1] ? m1_wdata : m0_wdata;
            cnt     <= '0;
            prio    <= pick[0];
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            s_valid <= 1'b0;
            timeout <= !s_ready;
            if (grant[1]) begin
              m1_rdata <= rsp;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= rsp;
              m0_ready <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        DONE: begin
          grant <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum BUSY cycles to wait for s_ready before aborting; legal range 2..255.
REQ-002 Parameter ERR_RDATA, default 32'hFFFF_FFFF: rdata returned to a master on timeout.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 m0_valid, m1_valid  input  1 each  master request.
REQ-006 m0_ready, m1_ready  output  1 each  registered one-cycle completion strobe.
REQ-007 m0_wstrb, m1_wstrb  input  4 each  byte write strobes; 0 means read.
REQ-008 m0_addr, m1_addr, m0_wdata, m1_wdata  input  32 each  request address and write data.
REQ-009 m0_rdata, m1_rdata  output  32 each  registered read data, valid while the matching ready is high.
REQ-010 s_valid  output  1  registered request to the shared peripheral port.
REQ-011 s_ready  input  1  peripheral completion.
REQ-012 s_wstrb  output  4;  s_addr, s_wdata  output  32;  s_rdata  input  32  shared peripheral request and response.
REQ-013 grant  output  2  one-hot owner of the current transaction; 2'b00 when idle.
REQ-014 timeout  output  1  one-cycle pulse when a transaction is aborted.

Function
REQ-015 State machine SHALL have three states: IDLE, BUSY, DONE.
REQ-016 IDLE: when any mX_valid is high, the arbiter SHALL select a master, capture its wstrb/addr/wdata into s_* registers, set grant, assert s_valid, clear the timeout counter, and enter BUSY on the next edge.
REQ-017 Selection SHALL be round-robin: a single requester wins; with both valid, the master flagged by the priority bit wins; after each grant, priority SHALL pass to the other master.
REQ-018 BUSY: s_valid and the s_* request fields SHALL stay stable; s_ready high SHALL capture s_rdata into the granted mX_rdata, drop s_valid, and enter DONE.
REQ-019 BUSY: if s_ready stays low for TIMEOUT consecutive BUSY cycles, the arbiter SHALL drop s_valid, load ERR_RDATA into the granted mX_rdata, pulse timeout for one cycle, and enter DONE.
REQ-020 If s_ready rises in the same cycle the counter expires, the arbiter SHALL treat it as success, with no timeout pulse.
REQ-021 DONE: the granted mX_ready SHALL be high for exactly one cycle, then the arbiter SHALL clear grant and return to IDLE; no new grant is issued in DONE.
REQ-022 s_ready SHALL be ignored in IDLE and DONE, which tolerates peripherals that hold ready one cycle after valid falls.
REQ-023 Latency SHALL be: valid sampled at edge N, s_valid high from N+1, m_ready high one cycle after the edge that samples s_ready. For a peripheral with ready registered from valid, ready appears at edge N+3.
REQ-024 A master deasserting valid during BUSY SHALL NOT abort the transaction; it completes and ready still pulses.
REQ-025 The non-granted master's ready SHALL remain low, and its rdata SHALL hold its last value.

Reset
REQ-026 Asserting reset SHALL immediately force: state IDLE; s_valid 0; s_wstrb/s_addr/s_wdata 0; m0/m1_ready 0; m0/m1_rdata 0; grant 2'b00; timeout 0; counter 0; priority to m0.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction with no ready or timeout pulse; after release, the arbiter SHALL arbitrate afresh from IDLE.

Structure
REQ-028 Shared package bus_arbiter_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and the default ERR_RDATA constant.
REQ-029 A single sub-module, bus_arbiter_rr, SHALL implement the combinational 2-way round-robin pick (inputs: valids, priority bit; output: one-hot select).
REQ-030 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL saturate; it SHALL NOT wrap.

Verification
REQ-031 m0 read, addr 0x0000_0008, peripheral with ready<=valid returning 32'h1 -> s_valid cycles N+1..N+2, m0_ready at N+3, m0_rdata=1, grant=2'b01 during the transaction.
REQ-032 m0 and m1 valid together, twice back-to-back, priority reset to m0 -> grants m0, m1, m0, m1 in order; never both ready at once.
REQ-033 m1 write wstrb=4'h1, wdata=1 to addr 0x4; peripheral never ready; TIMEOUT=16 -> s_valid for 16 cycles, timeout pulse once, m1_rdata=FFFF_FFFF, m1_ready once.
REQ-034 s_ready rising on the 16th BUSY cycle with s_rdata=32'hA5 -> m_rdata=A5, no timeout pulse.
REQ-035 reset asserted while in BUSY -> all outputs zero immediately; after release, a pending m1 request is granted cleanly.
REQ-036 peripheral holds ready high one extra cycle after s_valid drops while m1 is pending -> that stale ready is ignored, and m1's transaction waits for a fresh s_ready.
